// File: rtl/dsp_cfg_loader.sv
// Serialises CFG_BITS of host config LSB-first onto a DSP config chain; a word's bits appear 1..n cycles after its handshake.
// Host backpressure: cfg_ready is high only in LOAD, so the host holds cfg_word while the previous word shifts out.
module dsp_cfg_loader #(
  parameter int CFG_BITS   = 20,
  parameter int WORD_W     = 8,
  parameter int SETTLE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_word,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              configuration_input,
  output logic              configuration_enable,
  output logic              dsp_freeze,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  localparam int SW  = $clog2(CFG_BITS + 1);
  localparam int CW  = $clog2(WORD_W + 1);
  localparam int SCW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SHIFT  = 3'd2,
    SETTLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t            state;
  logic [SW-1:0]     sent;
  logic [CW-1:0]     rem;
  logic [SCW-1:0]    settle_cnt;
  logic [WORD_W-1:0] shreg;
  logic [WORD_W-1:0] sh_next;
  logic [CW-1:0]     chunk;

  assign cfg_ready = (state == LOAD);
  assign sh_next   = shreg >> 1;

  // The final word may only be partly used; its upper bits are never shifted.
  always_comb begin
    chunk = CW'(WORD_W);
    if (CFG_BITS - int'(sent) < WORD_W)
      chunk = CW'(CFG_BITS - int'(sent));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= IDLE;
      sent                 <= '0;
      rem                  <= '0;
      settle_cnt           <= '0;
      shreg                <= '0;
      configuration_input  <= 1'b0;
      configuration_enable <= 1'b0;
      dsp_freeze           <= 1'b0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      aborted              <= 1'b0;
    end else if (abort) begin
      // The DSP chain keeps whatever bits already went in; only our counters clear.
      state                <= IDLE;
      sent                 <= '0;
      rem                  <= '0;
      settle_cnt           <= '0;
      configuration_input  <= 1'b0;
      configuration_enable <= 1'b0;
      dsp_freeze           <= 1'b0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      aborted              <= 1'b1;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= LOAD;
            sent       <= '0;
            busy       <= 1'b1;
            dsp_freeze <= 1'b1;
          end
        end
        LOAD: begin
          if (cfg_valid) begin
            shreg                <= cfg_word;
            configuration_input  <= cfg_word[0];
            configuration_enable <= 1'b1;
            rem                  <= chunk;
            state                <= SHIFT;
          end
        end
        SHIFT: begin
          sent <= sent + 1'b1;
          if (rem > CW'(1)) begin
            shreg               <= sh_next;
            configuration_input <= sh_next[0];
            rem                 <= rem - 1'b1;
          end else begin
            configuration_enable <= 1'b0;
            configuration_input  <= 1'b0;
            rem                  <= '0;
            if (int'(sent) + 1 < CFG_BITS) begin
              state <= LOAD;
            end else begin
              state      <= SETTLE;
              settle_cnt <= '0;
            end
          end
        end
        SETTLE: begin
          if (int'(settle_cnt) >= SETTLE_CYC - 1) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        DONE: begin
          state      <= IDLE;
          sent       <= '0;
          busy       <= 1'b0;
          dsp_freeze <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
